// File: rtl/lcd_sequencer_if.sv
// lcd_sequencer_if
//   Groups the request handshake and the HD44780 pin bundle of lcd_sequencer.
//   Request side : req_valid, req_rs, req_data -> sequencer; req_ready,
//                  init_done <- sequencer.
//   LCD side     : lcd_data[7:0], lcd_en, lcd_rs, lcd_rw driven by sequencer.
//   Modports     : master = requester (Nios-side peripheral logic),
//                  slave  = the sequencer itself.
interface lcd_sequencer_if;
  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;
  logic       init_done;
  logic [7:0] lcd_data;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;

  modport master (
    output req_valid, req_rs, req_data,
    input  req_ready, init_done, lcd_data, lcd_en, lcd_rs, lcd_rw
  );

  modport slave (
    input  req_valid, req_rs, req_data,
    output req_ready, init_done, lcd_data, lcd_en, lcd_rs, lcd_rw
  );
endinterface

// File: rtl/lcd_sequencer.sv
// lcd_sequencer
//   Write-only sequencer for an HD44780-compatible character LCD (8-bit bus).
//   Accepts one instruction/character per valid/ready handshake, drives the
//   enable strobe with setup/pulse/hold timing, then waits the controller
//   execution time (long wait for clear/home) before accepting the next one.
//
//   Ports:
//     clk_clk        : clock, everything on its rising edge
//     reset_reset_n  : asynchronous active-low reset
//     bus (slave)    : req_valid/req_rs/req_data in, req_ready/init_done out,
//                      lcd_data/lcd_en/lcd_rs/lcd_rw out (all registered)
//
//   Build option LCD_SEQ_INIT_EN:
//     defined   - power-up delay followed by a six-entry init ROM
//                 (0x38,0x38,0x38,0x0C,0x01,0x06); init_done rises with the
//                 first entry into IDLE.
//     undefined - starts in IDLE, init_done tied high; software initialises
//                 the panel through the request port.
//
//   All timing parameters are in clock cycles and must be >= 1.
module lcd_sequencer #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_PULSE   = 12,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_SHORT   = 2000,
  parameter int unsigned T_LONG    = 82000
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  lcd_sequencer_if.slave  bus
);

  localparam int CW = 20;
  // Counter is loaded with (duration - 1); the state exits when it hits 0.
  localparam logic [CW-1:0] LD_POWERUP = CW'(T_POWERUP - 1);
  localparam logic [CW-1:0] LD_SETUP   = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_PULSE   = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] LD_HOLD    = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_SHORT   = CW'(T_SHORT - 1);
  localparam logic [CW-1:0] LD_LONG    = CW'(T_LONG - 1);

  typedef enum logic [2:0] {
    S_POWERUP, S_INIT_LOAD, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
  } state_e;

`ifdef LCD_SEQ_INIT_EN
  localparam state_e S_RESET = S_POWERUP;
`else
  localparam state_e S_RESET = S_IDLE;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    lcd_data_q, lcd_data_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic          lcd_en_q, lcd_en_d;
  logic          req_ready_q, req_ready_d;

`ifdef LCD_SEQ_INIT_EN
  logic          init_done_q, init_done_d;
  logic [2:0]    rom_idx_q, rom_idx_d;

  function automatic logic [7:0] rom_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: rom_byte = 8'h38;  // function set, repeated for wake-up
      3'd3:             rom_byte = 8'h0C;  // display on, cursor off
      3'd4:             rom_byte = 8'h01;  // clear
      3'd5:             rom_byte = 8'h06;  // entry mode, increment
      default:          rom_byte = 8'h00;
    endcase
  endfunction
`endif

  // Clear (0x01) and home (0x02/0x03) need the long execution time.
  logic wait_long;
  assign wait_long = !lcd_rs_q && (lcd_data_q[7:2] == 6'd0) && (lcd_data_q != 8'h00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lcd_data_d  = lcd_data_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_en_d    = 1'b0;
`ifdef LCD_SEQ_INIT_EN
    init_done_d = init_done_q;
    rom_idx_d   = rom_idx_q;
`endif
    case (state_q)
`ifdef LCD_SEQ_INIT_EN
      S_POWERUP: begin
        if (cnt_q == '0) state_d = S_INIT_LOAD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_INIT_LOAD: begin
        lcd_data_d = rom_byte(rom_idx_q);
        lcd_rs_d   = 1'b0;
        rom_idx_d  = rom_idx_q + 3'd1;
        cnt_d      = LD_SETUP;
        state_d    = S_SETUP;
      end
`endif
      S_IDLE: begin
        // req_ready_q gates the very first cycle after reset in the
        // no-init build, where the state is already IDLE.
        if (bus.req_valid && req_ready_q) begin
          lcd_data_d = bus.req_data;
          lcd_rs_d   = bus.req_rs;
          cnt_d      = LD_SETUP;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d    = LD_PULSE;
          lcd_en_d = 1'b1;
          state_d  = S_PULSE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = LD_HOLD;
          state_d = S_HOLD;
        end else begin
          cnt_d    = cnt_q - 1'b1;
          lcd_en_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          cnt_d   = wait_long ? LD_LONG : LD_SHORT;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
`ifdef LCD_SEQ_INIT_EN
          if (!init_done_q) begin
            if (rom_idx_q == 3'd6) init_done_d = 1'b1;
            else                   state_d     = S_INIT_LOAD;
          end
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_RESET;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_RESET;
      cnt_q       <= LD_POWERUP;
      lcd_data_q  <= 8'h00;
      lcd_rs_q    <= 1'b0;
      lcd_en_q    <= 1'b0;
      req_ready_q <= 1'b0;
`ifdef LCD_SEQ_INIT_EN
      init_done_q <= 1'b0;
      rom_idx_q   <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lcd_data_q  <= lcd_data_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_en_q    <= lcd_en_d;
      req_ready_q <= req_ready_d;
`ifdef LCD_SEQ_INIT_EN
      init_done_q <= init_done_d;
      rom_idx_q   <= rom_idx_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.lcd_data  = lcd_data_q;
  assign bus.lcd_rs    = lcd_rs_q;
  assign bus.lcd_en    = lcd_en_q;
  assign bus.lcd_rw    = 1'b0;
`ifdef LCD_SEQ_INIT_EN
  assign bus.init_done = init_done_q;
`else
  assign bus.init_done = 1'b1;
`endif

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer
//   Self-checking bench for lcd_sequencer with shortened timing. Expected
//   values come from a transaction-level model: each write's strobe window,
//   hold and ready-return cycle are computed from the timing parameters and
//   the clear/home rule. Builds with or without LCD_SEQ_INIT_EN.
module tb_lcd_sequencer;
  localparam int TPU = 100, TS = 2, TP = 4, TH = 2, TW_S = 20, TW_L = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lcd_sequencer_if u_if();

  lcd_sequencer #(
    .T_POWERUP(TPU), .T_SETUP(TS), .T_PULSE(TP),
    .T_HOLD(TH), .T_SHORT(TW_S), .T_LONG(TW_L)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (u_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef LCD_SEQ_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference rules: clear/home instructions take the long execution time.
  function automatic int wait_of(input bit rs, input logic [7:0] d);
    return (!rs && d >= 8'd1 && d <= 8'd3) ? TW_L : TW_S;
  endfunction

  function automatic int period_of(input bit rs, input logic [7:0] d);
    return 1 + TS + TP + TH + wait_of(rs, d);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (u_if.req_ready) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  // One write; samples are indexed n = edges after the acceptance edge.
  task automatic do_write(input bit rs, input logic [7:0] d, input bit noise);
    bit ok;
    int first_en = -1, en_hi = 0, rises = 0, rdy_n = -1;
    bit prev_en = 1'b0;
    int w = wait_of(rs, d);
    wait_ready(ok);
    if (!ok) return;
    u_if.req_valid = 1'b1; u_if.req_rs = rs; u_if.req_data = d;
    tick();
    u_if.req_valid = 1'b0; u_if.req_rs = ~rs; u_if.req_data = 8'($urandom);
    chk("wr_data", u_if.lcd_data, d);
    chk("wr_rs", u_if.lcd_rs, rs);
    for (int n = 0; n < 400; n++) begin
      if (u_if.lcd_en && !prev_en) rises++;
      if (u_if.lcd_en && first_en < 0) first_en = n;
      if (u_if.lcd_en) en_hi++;
      prev_en = u_if.lcd_en;
      if (n == TS + TP + TH - 1) begin
        chk("hold_data", u_if.lcd_data, d);
        chk("hold_rs", u_if.lcd_rs, rs);
      end
      if (noise && n == TS + 1) begin
        u_if.req_valid = 1'b1; u_if.req_data = 8'($urandom);
      end
      if (noise && n == TS + 2) u_if.req_valid = 1'b0;
      if (u_if.req_ready) begin rdy_n = n; break; end
      tick();
    end
    chk("en_first", first_en, TS);
    chk("en_width", en_hi, TP);
    chk("en_strobes", rises, 1);
    chk("ready_ret", rdy_n, TS + TP + TH + w);
    chk("idle_data", u_if.lcd_data, d);
    chk("rw_low", u_if.lcd_rw, 0);
  endtask

  task automatic do_b2b();
    bit ok;
    int gap = -1;
    wait_ready(ok);
    if (!ok) return;
    u_if.req_valid = 1'b1; u_if.req_rs = 1'b1; u_if.req_data = 8'h48;
    tick();
    u_if.req_data = 8'h49;
    for (int n = 0; n < 400; n++) begin
      if (u_if.req_ready) begin gap = n + 1; break; end
      tick();
    end
    tick();
    u_if.req_valid = 1'b0;
    chk("b2b_gap", gap, period_of(1'b1, 8'h48));
    chk("b2b_data2", u_if.lcd_data, 8'h49);
    wait_ready(ok);
  endtask

`ifdef LCD_SEQ_INIT_EN
  task automatic check_powerup();
    logic [7:0] rom [6];
    int k = 0, pulses = 0, last_hi = -1, hi_start = 0;
    bit prev = 1'b0, done = 1'b0;
    rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    while (k < 3000) begin
      tick(); k++;
      if (u_if.lcd_en && !prev) begin
        hi_start = k;
        if (pulses < 6) chk("pu_byte", u_if.lcd_data, rom[pulses]);
        chk("pu_rs", u_if.lcd_rs, 0);
        chk("pu_rw", u_if.lcd_rw, 0);
        if (pulses == 0) chk("pu_first", k, TPU + 1 + TS);
        else if (pulses <= 6)
          chk("pu_gap", k - last_hi - 1, TH + wait_of(1'b0, rom[pulses-1]) + 1 + TS);
        pulses++;
      end
      if (!u_if.lcd_en && prev) chk("pu_width", k - hi_start, TP);
      if (u_if.lcd_en) last_hi = k;
      if (u_if.req_ready || u_if.init_done) begin
        chk("pu_rdy_done", {u_if.req_ready, u_if.init_done}, 2'b11);
        chk("pu_count", pulses, 6);
        chk("pu_tail", k - last_hi - 1, TH + wait_of(1'b0, 8'h06));
        done = 1'b1;
        break;
      end
      prev = u_if.lcd_en;
    end
    if (!done) chk("pu_timeout", 0, 1);
  endtask
`else
  task automatic check_powerup();
    int strobes = 0;
    tick();
    chk("noinit_ready", u_if.req_ready, 1);
    chk("noinit_done", u_if.init_done, 1);
    for (int i = 0; i < 40; i++) begin
      if (u_if.lcd_en) strobes++;
      tick();
    end
    chk("noinit_no_en", strobes, 0);
  endtask
`endif

  task automatic check_reset_vals(input string tag);
    chk({tag, "_data"}, u_if.lcd_data, 8'h00);
    chk({tag, "_en"}, u_if.lcd_en, 0);
    chk({tag, "_rs"}, u_if.lcd_rs, 0);
    chk({tag, "_rw"}, u_if.lcd_rw, 0);
    chk({tag, "_ready"}, u_if.req_ready, 0);
    chk({tag, "_done"}, u_if.init_done, INIT_EN ? 0 : 1);
  endtask

  initial begin
    bit ok;
    u_if.req_valid = 1'b0; u_if.req_rs = 1'b0; u_if.req_data = 8'h00;
    repeat (3) tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    check_powerup();

    // Directed: data write, long/short commands, boundaries of the long rule.
    do_write(1'b0, 8'h38, 1'b0);
    do_write(1'b1, 8'h41, 1'b0);
    do_write(1'b0, 8'h01, 1'b0);
    do_write(1'b0, 8'h80, 1'b0);
    do_write(1'b0, 8'h03, 1'b0);
    do_write(1'b0, 8'h04, 1'b0);
    do_write(1'b0, 8'h00, 1'b0);
    do_write(1'b1, 8'h02, 1'b1);
    do_b2b();

    // Random writes, some with a stray req_valid during the strobe.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      bit rs;
      rs = 1'($urandom);
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      do_write(rs, d, 1'($urandom));
    end

    // Reset in the middle of an enable pulse.
    wait_ready(ok);
    u_if.req_valid = 1'b1; u_if.req_rs = 1'b1; u_if.req_data = 8'h5A;
    tick();
    u_if.req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (u_if.lcd_en) begin ok = 1'b1; break; end
      tick();
    end
    chk("mid_en_seen", ok, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid");
    tick(); tick();
    rst_n = 1'b1;
    check_powerup();
    do_write(1'b1, 8'h42, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "timeout");
  end
endmodule
